// File: rtl/video_timing_pkg.sv
// Shared raster constants for the 640x480@60 mode, plus the helper that sizes
// the column/row counters.
package video_timing_pkg;

    localparam int VGA_TOTAL_COLS       = 800;
    localparam int VGA_TOTAL_ROWS       = 525;
    localparam int VGA_ACTIVE_COLS      = 640;
    localparam int VGA_ACTIVE_ROWS      = 480;
    localparam int VGA_FRONT_PORCH_HORZ = 16;
    localparam int VGA_BACK_PORCH_HORZ  = 48;
    localparam int VGA_FRONT_PORCH_VERT = 10;
    localparam int VGA_BACK_PORCH_VERT  = 33;
    localparam int VGA_HSYNC_ACTIVE_LOW = 1;
    localparam int VGA_VSYNC_ACTIVE_LOW = 1;

    // Smallest counter width that can hold 0..total-1.
    function automatic int count_width_for(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

    localparam int VGA_COUNT_WIDTH =
        count_width_for((VGA_TOTAL_COLS > VGA_TOTAL_ROWS) ? VGA_TOTAL_COLS : VGA_TOTAL_ROWS);

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: a wrap counter advanced by i_Adv, with its position and
// window decodes registered whenever i_Upd is high.
module timing_axis_counter #(
    parameter int W      = 10,
    parameter int TOTAL  = 800,
    parameter int ACTIVE = 640,
    parameter int WIN_LO = 656,
    parameter int WIN_HI = 752
) (
    input  logic         i_Clk,
    input  logic         i_Rst,
    input  logic         i_Adv,
    input  logic         i_Upd,
    output logic [W-1:0] o_Count,
    output logic         o_Last,
    output logic         o_Active,
    output logic         o_Window,
    output logic         o_Wrapped
);

    localparam logic [W-1:0] LAST  = W'(TOTAL - 1);
    // One extra bit so a bound equal to 2**W still compares correctly.
    localparam logic [W:0]   ACT_X = (W+1)'(ACTIVE);
    localparam logic [W:0]   LO_X  = (W+1)'(WIN_LO);
    localparam logic [W:0]   HI_X  = (W+1)'(WIN_HI);

    logic [W-1:0] cnt;
    logic [W:0]   cnt_x;

    assign o_Last = (cnt == LAST);
    assign cnt_x  = {1'b0, cnt};

    always_ff @(posedge i_Clk) begin
        if (i_Rst)
            cnt <= '0;
        else if (i_Adv)
            cnt <= o_Last ? '0 : cnt + W'(1);
    end

    // o_Wrapped is a strobe: it clears on any cycle without an update.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Count   <= '0;
            o_Active  <= 1'b0;
            o_Window  <= 1'b0;
            o_Wrapped <= 1'b0;
        end else begin
            o_Wrapped <= i_Upd && (cnt == '0);
            if (i_Upd) begin
                o_Count  <= cnt;
                o_Active <= (cnt_x < ACT_X);
                o_Window <= (cnt_x >= LO_X) && (cnt_x < HI_X);
            end
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: active-region syncs, monitor sync pulses, blanking,
// counters and line/frame strobes, all registered with one enabled-cycle latency.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int TOTAL_COLS       = VGA_TOTAL_COLS,
    parameter int TOTAL_ROWS       = VGA_TOTAL_ROWS,
    parameter int ACTIVE_COLS      = VGA_ACTIVE_COLS,
    parameter int ACTIVE_ROWS      = VGA_ACTIVE_ROWS,
    parameter int FRONT_PORCH_HORZ = VGA_FRONT_PORCH_HORZ,
    parameter int BACK_PORCH_HORZ  = VGA_BACK_PORCH_HORZ,
    parameter int FRONT_PORCH_VERT = VGA_FRONT_PORCH_VERT,
    parameter int BACK_PORCH_VERT  = VGA_BACK_PORCH_VERT,
    parameter int HSYNC_ACTIVE_LOW = VGA_HSYNC_ACTIVE_LOW,
    parameter int VSYNC_ACTIVE_LOW = VGA_VSYNC_ACTIVE_LOW,
    parameter int COUNT_WIDTH      = VGA_COUNT_WIDTH
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_Ce,
    output logic                   o_HSync,
    output logic                   o_VSync,
    output logic                   o_HSync_Pulse,
    output logic                   o_VSync_Pulse,
    output logic                   o_HBlank,
    output logic                   o_VBlank,
    output logic [COUNT_WIDTH-1:0] o_Col_Count,
    output logic [COUNT_WIDTH-1:0] o_Row_Count,
    output logic                   o_Line_Start,
    output logic                   o_Frame_Start
);

    localparam int  H_SYNC_W = TOTAL_COLS - ACTIVE_COLS - FRONT_PORCH_HORZ - BACK_PORCH_HORZ;
    localparam int  V_SYNC_W = TOTAL_ROWS - ACTIVE_ROWS - FRONT_PORCH_VERT - BACK_PORCH_VERT;
    localparam logic HS_POL  = (HSYNC_ACTIVE_LOW != 0);
    localparam logic VS_POL  = (VSYNC_ACTIVE_LOW != 0);

    if (TOTAL_COLS > 2**COUNT_WIDTH) begin : g_bad_cols
        $error("video_timing_gen: TOTAL_COLS does not fit in COUNT_WIDTH");
    end
    if (TOTAL_ROWS > 2**COUNT_WIDTH) begin : g_bad_rows
        $error("video_timing_gen: TOTAL_ROWS does not fit in COUNT_WIDTH");
    end
    if (H_SYNC_W < 1) begin : g_bad_hsync
        $error("video_timing_gen: horizontal sync width must be at least 1");
    end
    if (V_SYNC_W < 1) begin : g_bad_vsync
        $error("video_timing_gen: vertical sync width must be at least 1");
    end

    logic h_last, h_win, h_wrapped;
    logic v_last_unused, v_win, v_wrapped;

    timing_axis_counter #(
        .W      (COUNT_WIDTH),
        .TOTAL  (TOTAL_COLS),
        .ACTIVE (ACTIVE_COLS),
        .WIN_LO (ACTIVE_COLS + FRONT_PORCH_HORZ),
        .WIN_HI (TOTAL_COLS - BACK_PORCH_HORZ)
    ) u_horz (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Adv     (i_Ce),
        .i_Upd     (i_Ce),
        .o_Count   (o_Col_Count),
        .o_Last    (h_last),
        .o_Active  (o_HSync),
        .o_Window  (h_win),
        .o_Wrapped (h_wrapped)
    );

    // Rows step only on the column wrap, but their decode refreshes every pixel.
    timing_axis_counter #(
        .W      (COUNT_WIDTH),
        .TOTAL  (TOTAL_ROWS),
        .ACTIVE (ACTIVE_ROWS),
        .WIN_LO (ACTIVE_ROWS + FRONT_PORCH_VERT),
        .WIN_HI (TOTAL_ROWS - BACK_PORCH_VERT)
    ) u_vert (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Adv     (i_Ce & h_last),
        .i_Upd     (i_Ce),
        .o_Count   (o_Row_Count),
        .o_Last    (v_last_unused),
        .o_Active  (o_VSync),
        .o_Window  (v_win),
        .o_Wrapped (v_wrapped)
    );

    assign o_HSync_Pulse = h_win ^ HS_POL;
    assign o_VSync_Pulse = v_win ^ VS_POL;
    assign o_HBlank      = ~o_HSync;
    assign o_VBlank      = ~o_VSync;
    assign o_Line_Start  = h_wrapped;
    assign o_Frame_Start = h_wrapped & v_wrapped;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small 20x10 raster, compared cycle by cycle
// against a linear-position reference model.
module tb_video_timing_gen;

    localparam int TC = 20, AC = 12, FPH = 2, BPH = 3;
    localparam int TR = 10, AR = 6,  FPV = 1, BPV = 2;
    localparam int CW = 5;

    logic clk = 1'b0, rst = 1'b1, ce = 1'b0;
    logic hs, vs, hp, vp, hb, vb, ls, fs;
    logic [CW-1:0] col, row;
    logic b_hs, b_vs, b_hp, b_vp, b_hb, b_vb, b_ls, b_fs;
    logic [CW-1:0] b_col, b_row;

    always #5 clk = ~clk;

    video_timing_gen #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .FRONT_PORCH_HORZ(FPH), .BACK_PORCH_HORZ(BPH),
        .FRONT_PORCH_VERT(FPV), .BACK_PORCH_VERT(BPV),
        .HSYNC_ACTIVE_LOW(1), .VSYNC_ACTIVE_LOW(1), .COUNT_WIDTH(CW)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Ce(ce),
        .o_HSync(hs), .o_VSync(vs), .o_HSync_Pulse(hp), .o_VSync_Pulse(vp),
        .o_HBlank(hb), .o_VBlank(vb), .o_Col_Count(col), .o_Row_Count(row),
        .o_Line_Start(ls), .o_Frame_Start(fs)
    );

    video_timing_gen #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .FRONT_PORCH_HORZ(FPH), .BACK_PORCH_HORZ(BPH),
        .FRONT_PORCH_VERT(FPV), .BACK_PORCH_VERT(BPV),
        .HSYNC_ACTIVE_LOW(0), .VSYNC_ACTIVE_LOW(1), .COUNT_WIDTH(CW)
    ) dut_hi (
        .i_Clk(clk), .i_Rst(rst), .i_Ce(ce),
        .o_HSync(b_hs), .o_VSync(b_vs), .o_HSync_Pulse(b_hp), .o_VSync_Pulse(b_vp),
        .o_HBlank(b_hb), .o_VBlank(b_vb), .o_Col_Count(b_col), .o_Row_Count(b_row),
        .o_Line_Start(b_ls), .o_Frame_Start(b_fs)
    );

    int checks = 0, errors = 0, cyc = 0;

    // Reference model: m_pos is the linear raster position (row*TC+col) emitted next.
    int m_pos;
    int e_col, e_row;
    logic e_hs, e_vs, e_hp, e_vp, e_hp_hi, e_ls, e_fs;

    int last_ls, last_fs, ls_per, fs_per;
    int hp_low, vp_low, b_hp_high;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic r, input logic c);
        int mc, mr;
        if (r) begin
            m_pos = 0;
            e_col = 0; e_row = 0;
            e_hs = 0; e_vs = 0;
            e_hp = 1; e_vp = 1; e_hp_hi = 0;
            e_ls = 0; e_fs = 0;
        end else if (c) begin
            mc = m_pos % TC;
            mr = m_pos / TC;
            e_col   = mc;
            e_row   = mr;
            e_hs    = (mc < AC);
            e_vs    = (mr < AR);
            e_hp_hi = (mc >= AC + FPH) && (mc < TC - BPH);
            e_hp    = !e_hp_hi;
            e_vp    = !((mr >= AR + FPV) && (mr < TR - BPV));
            e_ls    = (mc == 0);
            e_fs    = (m_pos == 0);
            m_pos   = (m_pos + 1) % (TC * TR);
        end else begin
            e_ls = 0;
            e_fs = 0;
        end
    endtask

    task automatic step(input logic r, input logic c);
        rst = r;
        ce  = c;
        @(posedge clk);
        model_edge(r, c);
        cyc++;
        #1;
        chk("col", 32'(col), 32'(e_col));
        chk("row", 32'(row), 32'(e_row));
        chk("hsync", 32'(hs), 32'(e_hs));
        chk("vsync", 32'(vs), 32'(e_vs));
        chk("hblank", 32'(hb), 32'(!e_hs));
        chk("vblank", 32'(vb), 32'(!e_vs));
        chk("hsync_pulse", 32'(hp), 32'(e_hp));
        chk("vsync_pulse", 32'(vp), 32'(e_vp));
        chk("line_start", 32'(ls), 32'(e_ls));
        chk("frame_start", 32'(fs), 32'(e_fs));
        chk("hsync_pulse_hi", 32'(b_hp), 32'(e_hp_hi));
        if (hp == 1'b0) hp_low++;
        if (vp == 1'b0) vp_low++;
        if (b_hp == 1'b1) b_hp_high++;
        if (ls) begin
            if (last_ls >= 0 && ls_per != 0) chk("line_period", 32'(cyc - last_ls), 32'(ls_per));
            last_ls = cyc;
        end
        if (fs) begin
            if (last_fs >= 0 && fs_per != 0) chk("frame_period", 32'(cyc - last_fs), 32'(fs_per));
            last_fs = cyc;
        end
    endtask

    task automatic phase(input int lp, input int fp);
        last_ls = -1; last_fs = -1; ls_per = lp; fs_per = fp;
    endtask

    initial begin
        int n;
        phase(0, 0);

        // Reset state
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("rst_hsync", 32'(hs), 32'd0);
        chk("rst_hblank", 32'(hb), 32'd1);
        chk("rst_hpulse_inactive", 32'(hp), 32'd1);
        chk("rst_hpulse_hi_inactive", 32'(b_hp), 32'd0);

        // First enabled output after reset, then two full frames at full rate
        phase(TC, TC * TR);
        step(1'b0, 1'b1);
        chk("first_col", 32'(col), 32'd0);
        chk("first_fs", 32'(fs), 32'd1);
        chk("first_ls", 32'(ls), 32'd1);
        chk("first_hsync", 32'(hs), 32'd1);
        chk("first_vsync", 32'(vs), 32'd1);
        hp_low = 0; vp_low = 0; b_hp_high = 0;
        for (int i = 0; i < TC * TR; i++) step(1'b0, 1'b1);
        chk("hpulse_low_per_frame", 32'(hp_low), 32'(TR * (TC - AC - FPH - BPH)));
        chk("vpulse_low_per_frame", 32'(vp_low), 32'(TC * (TR - AR - FPV - BPV)));
        chk("hpulse_hi_per_frame", 32'(b_hp_high), 32'(TR * (TC - AC - FPH - BPH)));
        chk("wrap_to_origin", 32'({row, col}), 32'd0);
        for (int i = 0; i < TC * TR; i++) step(1'b0, 1'b1);

        // Alternating clock enable: everything runs at half rate
        phase(2 * TC, 0);
        for (int i = 0; i < 8 * TC; i++) step(1'b0, 1'(i % 2 == 0));

        // Random enable pattern with occasional resets
        phase(0, 0);
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 2) != 0));

        // Reset mid-frame at (5,3) with enable high
        phase(0, 0);
        n = 0;
        while (!(e_col == 5 && e_row == 3 && ls === 1'b0) && n < 2 * TC * TR) begin
            step(1'b0, 1'b1);
            n++;
        end
        chk("reach_5_3", 32'(n < 2 * TC * TR), 32'd1);
        step(1'b1, 1'b1);
        chk("midrst_col", 32'(col), 32'd0);
        chk("midrst_row", 32'(row), 32'd0);
        chk("midrst_fs", 32'(fs), 32'd0);
        chk("midrst_vblank", 32'(vb), 32'd1);
        step(1'b0, 1'b1);
        chk("post_rst_fs", 32'(fs), 32'd1);
        for (int i = 0; i < 50; i++) step(1'b0, 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
